// File: rtl/controle_multiciclo.sv
// Multicycle sequencer for the MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/write-back and drives the step code and enables.
module controle_multiciclo #(
    parameter logic [5:0] OPCODE_HALT        = 6'h3F,
    parameter int         LARGURA_CONT_INSTR = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [5:0]                    opcode,
    input  logic                          zero,
    input  logic                          mem_pronto,
    output logic [3:0]                    cont,
    output logic [1:0]                    pc_fonte,
    output logic                          mem_ler,
    output logic                          mem_escrever,
    output logic                          ir_escrever,
    output logic                          reg_escrever,
    output logic                          reg_dst,
    output logic                          mem_para_reg,
    output logic                          ula_fonte,
    output logic [1:0]                    ula_op,
    output logic                          parado,
    output logic                          op_invalido,
    output logic [LARGURA_CONT_INSTR-1:0] instr_count
);

    typedef enum logic [3:0] {
        INICIO = 4'd0,
        PC     = 4'd1,
        BUSCA  = 4'd2,
        DECOD  = 4'd3,
        EXEC   = 4'd4,
        MEM    = 4'd5,
        ESCR   = 4'd6,
        PARADO = 4'd15
    } estado_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    estado_t                       state_reg, state_next;
    logic [5:0]                    op_reg;
    logic [1:0]                    pc_fonte_reg, pc_fonte_next;
    logic                          op_invalido_reg, op_invalido_set;
    logic [LARGURA_CONT_INSTR-1:0] instr_count_reg;
    logic                          op_conhecido;

    assign op_conhecido = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                          (opcode == OP_BEQ) || (opcode == OP_ADDI);

    // State, latched opcode, next-PC select, sticky flag and retired counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= INICIO;
            op_reg          <= 6'd0;
            pc_fonte_reg    <= 2'b00;
            op_invalido_reg <= 1'b0;
            instr_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_fonte_reg <= pc_fonte_next;
            if (state_reg == DECOD)
                op_reg <= opcode;
            if (op_invalido_set)
                op_invalido_reg <= 1'b1;
            if (state_next == PC)
                instr_count_reg <= instr_count_reg + LARGURA_CONT_INSTR'(1);
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_fonte_next   = pc_fonte_reg;
        op_invalido_set = 1'b0;
        case (state_reg)
            INICIO: begin
                state_next    = BUSCA;
                pc_fonte_next = 2'b00;
            end
            PC: begin
                // PC has consumed the select on this edge; fetch starts clean
                state_next    = BUSCA;
                pc_fonte_next = 2'b00;
            end
            BUSCA: begin
                if (mem_pronto)
                    state_next = DECOD;
            end
            DECOD: begin
                if (opcode == OP_J) begin
                    pc_fonte_next = 2'b10;
                    state_next    = PC;
                end else if (op_conhecido) begin
                    state_next = EXEC;
                end else if (opcode == OPCODE_HALT) begin
                    state_next = PARADO;
                end else begin
                    op_invalido_set = 1'b1;
                    pc_fonte_next   = 2'b00;
                    state_next      = PC;
                end
            end
            EXEC: begin
                case (op_reg)
                    OP_R, OP_ADDI: state_next = ESCR;
                    OP_LW, OP_SW:  state_next = MEM;
                    OP_BEQ: begin
                        pc_fonte_next = zero ? 2'b01 : 2'b00;
                        state_next    = PC;
                    end
                    default:       state_next = PC;
                endcase
            end
            MEM: begin
                if (mem_pronto)
                    state_next = (op_reg == OP_LW) ? ESCR : PC;
            end
            ESCR:    state_next = PC;
            PARADO:  state_next = PARADO;
            default: state_next = INICIO;
        endcase
    end

    always_comb begin
        mem_ler      = 1'b0;
        mem_escrever = 1'b0;
        ir_escrever  = 1'b0;
        reg_escrever = 1'b0;
        reg_dst      = 1'b0;
        mem_para_reg = 1'b0;
        ula_fonte    = 1'b0;
        ula_op       = 2'b00;
        case (state_reg)
            BUSCA: begin
                mem_ler     = 1'b1;
                ir_escrever = mem_pronto;
            end
            EXEC: begin
                case (op_reg)
                    OP_R:                 ula_op = 2'b10;
                    OP_LW, OP_SW, OP_ADDI: ula_fonte = 1'b1;
                    OP_BEQ:               ula_op = 2'b01;
                    default:              ula_op = 2'b00;
                endcase
            end
            MEM: begin
                mem_ler      = (op_reg == OP_LW);
                mem_escrever = (op_reg == OP_SW);
            end
            ESCR: begin
                reg_escrever = 1'b1;
                reg_dst      = (op_reg == OP_R);
                mem_para_reg = (op_reg == OP_LW);
            end
            default: ;
        endcase
    end

    assign cont        = state_reg;
    assign pc_fonte    = pc_fonte_reg;
    assign parado      = (state_reg == PARADO);
    assign op_invalido = op_invalido_reg;
    assign instr_count = instr_count_reg;

endmodule
